axi_stream_pkt_capture: RTL

// - Receive end of if_axi_stream: accepts one packet, stores it in on-chip RAM, then exposes it via a random-access read port.
// - Hardware counterpart of a bench get_stream; sits downstream of pipeline_if as the terminal sink for host/debug readback.
// - Single packet buffered; no new packet is accepted until software/logic releases the buffer.

---
 rtl/axi_stream_pkt_capture_pkg.sv | 25 ++
 rtl/if_axi_stream.sv | 26 ++
 rtl/axi_stream_pkt_capture_ram.sv | 43 ++++
 rtl/axi_stream_pkt_capture.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkt_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_pkg
// Brief    : Shared types and helpers for the stream packet capture block.
// Revision : 1.0 - initial release
// ============================================================================
package common_pkg;

  // Capture FSM states: waiting for sop, collecting words, holding a packet
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RECV = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_t;

  // Byte length of a packet: full words plus the partial last word
  // (mod == 0 means the last word is fully populated)
  function automatic logic [31:0] pkt_byte_len(input logic [31:0] nwords,
                                               input logic [31:0] mod,
                                               input logic [31:0] dat_byts);
    pkt_byte_len = (nwords - 32'd1) * dat_byts + ((mod == 32'd0) ? dat_byts : mod);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_axi_stream.sv
`default_nettype none
// ============================================================================
// Module   : if_axi_stream
// Brief    : Word-wide stream with sop/eop framing, error, byte-count and
//            control sideband; rdy flows back from the sink.
// Revision : 1.0 - initial release
// ============================================================================
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;
  logic                  rdy;

  modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface
`default_nettype wire

// File: rtl/axi_stream_pkt_capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : pkt_capture_ram
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port. Storage is never cleared; only the read register resets.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_capture_ram
  import common_pkg::*;
#(
  parameter int DAT_W     = 64,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DAT_W-1:0]     i_wdat,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DAT_W-1:0]     o_rdat
);

  logic [DAT_W-1:0] r_mem [DEPTH];

  // Write port: store the accepted stream word
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  // Read port: one-cycle registered readback, cleared by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rdat <= '0;
    end else begin
      o_rdat <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_stream_pkt_capture.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_pkt_capture
// Brief    : Terminal stream sink. Captures one packet into on-chip RAM,
//            reports length/ctl/err/overflow, and holds it for random-access
//            readback until released.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_pkt_capture
  import common_pkg::*;
#(
  parameter  int DAT_BYTS  = 8,
  parameter  int CTL_BITS  = 8,
  parameter  int MAX_WORDS = 256,
  localparam int ADDR_BITS = $clog2(MAX_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  if_axi_stream.sink            i_axi,
  output logic                  o_done,
  output logic [31:0]           o_len,
  output logic [CTL_BITS-1:0]   o_ctl,
  output logic                  o_err,
  output logic                  o_ovf,
  input  logic                  i_release,
  input  logic [ADDR_BITS-1:0]  i_rd_addr,
  output logic [DAT_BYTS*8-1:0] o_rd_dat
);

  localparam logic [ADDR_BITS:0] C_MAX_WCNT = (ADDR_BITS+1)'(MAX_WORDS);
  localparam logic [31:0]        C_DAT_BYTS = 32'(DAT_BYTS);
  localparam logic [31:0]        C_MAX_LEN  = 32'(MAX_WORDS * DAT_BYTS);

  cap_state_t           r_state;
  cap_state_t           w_state_nxt;
  logic                 r_rdy;
  logic [ADDR_BITS:0]   r_wcnt;     // words written so far, saturates at MAX_WORDS
  logic [CTL_BITS-1:0]  r_ctl;      // ctl of the packet in progress
  logic                 r_err_acc;  // err accumulated over the packet in progress
  logic                 r_ovf_acc;  // at least one word dropped in this packet

  logic                 w_xfer;
  logic                 w_room;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic                 w_restart;
  logic                 w_eop_ovf;
  logic                 w_eop_err;
  logic [31:0]          w_eop_words;
  logic [31:0]          w_eop_len;
  logic [CTL_BITS-1:0]  w_eop_ctl;

  assign w_xfer    = i_axi.val & r_rdy;
  assign w_room    = (r_wcnt < C_MAX_WCNT);
  assign i_axi.rdy = r_rdy;

  // A word carrying sop (or any accepted word in IDLE) starts a fresh packet;
  // these terms describe the packet as it will stand once the eop word lands
  assign w_restart   = (r_state == CAP_IDLE) || i_axi.sop;
  assign w_eop_ovf   = !w_restart && (r_ovf_acc || !w_room);
  assign w_eop_words = w_restart ? 32'd1 : (32'(r_wcnt) + 32'd1);
  assign w_eop_len   = w_eop_ovf ? C_MAX_LEN
                                 : pkt_byte_len(w_eop_words, 32'(i_axi.mod), C_DAT_BYTS);
  assign w_eop_err   = i_axi.err | ((r_state == CAP_RECV) && (r_err_acc || i_axi.sop));
  assign w_eop_ctl   = w_restart ? i_axi.ctl : r_ctl;

  // Next-state and RAM write control
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = '0;
    case (r_state)
      CAP_IDLE: begin
        if (w_xfer && i_axi.sop) begin
          w_we        = 1'b1;
          w_state_nxt = i_axi.eop ? CAP_DONE : CAP_RECV;
        end
      end
      CAP_RECV: begin
        if (w_xfer) begin
          if (i_axi.sop) begin
            w_we = 1'b1;
          end else if (w_room) begin
            w_we    = 1'b1;
            w_waddr = r_wcnt[ADDR_BITS-1:0];
          end
          if (i_axi.eop) begin
            w_state_nxt = CAP_DONE;
          end
        end
      end
      CAP_DONE: begin
        if (i_release) begin
          w_state_nxt = CAP_IDLE;
        end
      end
      default: w_state_nxt = CAP_IDLE;
    endcase
  end

  // State register; rdy is registered and low whenever a packet is held
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= CAP_IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt != CAP_DONE);
    end
  end

  // Word counter and per-packet accumulators
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wcnt    <= '0;
      r_ctl     <= '0;
      r_err_acc <= 1'b0;
      r_ovf_acc <= 1'b0;
    end else if (w_xfer) begin
      if ((r_state == CAP_IDLE && i_axi.sop) || (r_state == CAP_RECV && i_axi.sop)) begin
        r_wcnt    <= (ADDR_BITS+1)'(1);
        r_ctl     <= i_axi.ctl;
        r_err_acc <= i_axi.err | (r_state == CAP_RECV);
        r_ovf_acc <= 1'b0;
      end else if (r_state == CAP_RECV) begin
        r_err_acc <= r_err_acc | i_axi.err;
        if (w_room) begin
          r_wcnt <= r_wcnt + 1'b1;
        end else begin
          r_ovf_acc <= 1'b1;
        end
      end
    end
  end

  // Status outputs: published on entry to DONE, flags cleared on release
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_done <= 1'b0;
      o_len  <= '0;
      o_ctl  <= '0;
      o_err  <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (r_state != CAP_DONE && w_state_nxt == CAP_DONE) begin
      o_done <= 1'b1;
      o_len  <= w_eop_len;
      o_ctl  <= w_eop_ctl;
      o_err  <= w_eop_err;
      o_ovf  <= w_eop_ovf;
    end else if (r_state == CAP_DONE && i_release) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_ovf  <= 1'b0;
    end
  end

  pkt_capture_ram #(
    .DAT_W     (DAT_BYTS*8),
    .DEPTH     (MAX_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (i_axi.dat),
    .i_raddr (i_rd_addr),
    .o_rdat  (o_rd_dat)
  );

endmodule
`default_nettype wire
